// File: rtl/data_cache_if.sv
// CPU MEM-stage request bus between the pipeline (master) and the data cache (slave).
interface data_cache_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 c_read;
  logic                 c_write;
  logic [WORD_SIZE-1:0] c_addr;
  logic [WORD_SIZE-1:0] c_wdata;
  logic [WORD_SIZE-1:0] c_rdata;
  logic                 c_ready;

  modport master (
    output c_read, c_write, c_addr, c_wdata,
    input  c_rdata, c_ready
  );

  modport slave (
    input  c_read, c_write, c_addr, c_wdata,
    output c_rdata, c_ready
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache: 4 lines x 4 words,
// read hits complete in the request cycle, misses and writes stall via c_ready.
//
// state | meaning
// IDLE  | serve read hits, detect misses and writes
// FILL  | line-fill read from memory, waiting for m_ready
// WRITE | single-word write-through, waiting for m_ready
module data_cache #(
  parameter int WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  data_cache_if.slave            cpu,
  output logic                   m_read,
  output logic                   m_write,
  output logic [WORD_SIZE-1:0]   m_addr,
  output logic [WORD_SIZE-1:0]   m_wdata,
  input  logic [4*WORD_SIZE-1:0] m_rdata,
  input  logic                   m_ready,
  output logic [WORD_SIZE-1:0]   hit_count,
  output logic [WORD_SIZE-1:0]   miss_count
);

  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;
  localparam int TAG_W      = WORD_SIZE - 4;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_mem [NUM_LINES][LINE_WORDS];

  logic [WORD_SIZE-1:0] req_addr;
  logic                 req_hit;
  logic                 refill;

  logic [1:0]       c_idx;
  logic [1:0]       c_off;
  logic [TAG_W-1:0] c_tag;
  logic [1:0]       req_idx;
  logic [1:0]       req_off;
  logic             hit;
  logic             rd_req;
  logic             wr_req;
  logic             rd_hit;
  logic             wr_done;
  logic             fill_done;

  assign c_idx   = cpu.c_addr[3:2];
  assign c_off   = cpu.c_addr[1:0];
  assign c_tag   = cpu.c_addr[WORD_SIZE-1:4];
  assign req_idx = req_addr[3:2];
  assign req_off = req_addr[1:0];

  assign hit    = valid[c_idx] && (tag_mem[c_idx] == c_tag);
  // A simultaneous read and write is served as a read.
  assign rd_req = cpu.c_read;
  assign wr_req = cpu.c_write & ~cpu.c_read;

  assign rd_hit    = !reset && (state == IDLE) && rd_req && hit;
  assign wr_done   = !reset && (state == WRITE) && m_ready;
  assign fill_done = !reset && (state == FILL) && m_ready;

  assign cpu.c_ready = rd_hit | wr_done;
  assign cpu.c_rdata = rd_hit ? data_mem[c_idx][c_off] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      req_addr   <= '0;
      req_hit    <= 1'b0;
      refill     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          refill <= 1'b0;
          if (rd_req) begin
            if (hit) begin
              // The re-hit that completes a fill was already counted as a miss.
              if (!refill) hit_count <= hit_count + 1'b1;
            end else begin
              miss_count <= miss_count + 1'b1;
              req_addr   <= cpu.c_addr;
              m_read     <= 1'b1;
              m_addr     <= {cpu.c_addr[WORD_SIZE-1:2], 2'b00};
              state      <= FILL;
            end
          end else if (wr_req) begin
            req_addr <= cpu.c_addr;
            req_hit  <= hit;
            m_write  <= 1'b1;
            m_addr   <= cpu.c_addr;
            m_wdata  <= cpu.c_wdata;
            state    <= WRITE;
          end
        end
        FILL: begin
          if (m_ready) begin
            valid[req_idx] <= 1'b1;
            refill         <= 1'b1;
            m_read         <= 1'b0;
            m_addr         <= '0;
            state          <= IDLE;
          end
        end
        WRITE: begin
          if (m_ready) begin
            if (req_hit) hit_count  <= hit_count + 1'b1;
            else         miss_count <= miss_count + 1'b1;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone decides hits.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[req_idx] <= req_addr[WORD_SIZE-1:4];
      for (int k = 0; k < LINE_WORDS; k++) begin
        data_mem[req_idx][k] <= m_rdata[k*WORD_SIZE +: WORD_SIZE];
      end
    end else if (wr_done && req_hit) begin
      data_mem[req_idx][req_off] <= m_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: reference model plus scoreboard of expected completions.
module tb_data_cache;
  logic        clk;
  logic        reset;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  data_cache_if #(.WORD_SIZE(16)) bus ();

  data_cache #(.WORD_SIZE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .m_read     (m_read),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          cycle;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit          r_valid [4];
  logic [11:0] r_tag   [4];
  logic [15:0] r_data  [4][4];
  logic [15:0] r_mem   [int];
  int          r_hit;
  int          r_miss;

  // Memory as seen on the bus (written only by DUT write-throughs)
  logic [15:0] bus_mem [int];

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    if (r_mem.exists(int'(a))) return r_mem[int'(a)];
    return 16'(int'(a) * 3 + 'h100);
  endfunction

  function automatic logic [15:0] bus_word(input logic [15:0] a);
    if (bus_mem.exists(int'(a))) return bus_mem[int'(a)];
    return 16'(int'(a) * 3 + 'h100);
  endfunction

  function automatic logic [63:0] bus_line(input logic [15:0] a);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[k*16 +: 16] = bus_word({a[15:2], 2'(k)});
    return l;
  endfunction

  task automatic check_counts(input string name);
    total++;
    if (hit_count !== 16'(r_hit)) begin
      bad++;
      $error("FAIL %s/hit_count observed=%0h expected=%0h", name, hit_count, 16'(r_hit));
    end
    total++;
    if (miss_count !== 16'(r_miss)) begin
      bad++;
      $error("FAIL %s/miss_count observed=%0h expected=%0h", name, miss_count, 16'(r_miss));
    end
  endtask

  // Present one request at posedge+1 and act as memory with latency lat.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int lat, input string name);
    logic [1:0]  ix;
    logic [15:0] exp_maddr;
    bit          h;
    int          exp_act;
    int          cyc;
    int          act;
    bit          done;
    exp_t        e;
    exp_t        got;

    ix = addr[3:2];
    h  = r_valid[ix] && (r_tag[ix] == addr[15:4]);
    if (rd) begin
      if (h) begin
        r_hit++;
        e.cycle = 0;
        exp_act = 0;
      end else begin
        for (int k = 0; k < 4; k++) r_data[ix][k] = ref_word({addr[15:2], 2'(k)});
        r_valid[ix] = 1'b1;
        r_tag[ix]   = addr[15:4];
        r_miss++;
        e.cycle = lat + 1;
        exp_act = lat;
      end
      e.data    = r_data[ix][addr[1:0]];
      exp_maddr = {addr[15:2], 2'b00};
    end else begin
      if (h) begin
        r_data[ix][addr[1:0]] = wd;
        r_hit++;
      end else begin
        r_miss++;
      end
      r_mem[int'(addr)] = wd;
      e.cycle   = lat;
      e.data    = '0;
      exp_act   = lat;
      exp_maddr = addr;
    end
    e.rd = rd;
    exp_q.push_back(e);

    bus.c_read  = rd;
    bus.c_write = wr;
    bus.c_addr  = addr;
    bus.c_wdata = wd;
    cyc  = 0;
    act  = 0;
    done = 1'b0;
    while (!done && cyc <= 40) begin
      if (m_read || m_write) begin
        act++;
        total++;
        if (m_addr !== exp_maddr) begin
          bad++;
          $error("FAIL %s/m_addr observed=%0h expected=%0h", name, m_addr, exp_maddr);
        end
        total++;
        if ((m_read & m_write) !== 1'b0) begin
          bad++;
          $error("FAIL %s/m_read_and_m_write observed=%0h expected=0", name, m_read & m_write);
        end
        total++;
        if (m_write !== logic'(!rd)) begin
          bad++;
          $error("FAIL %s/m_kind observed=%0h expected=%0h", name, m_write, !rd);
        end
        if (m_write) begin
          total++;
          if (m_wdata !== wd) begin
            bad++;
            $error("FAIL %s/m_wdata observed=%0h expected=%0h", name, m_wdata, wd);
          end
        end
        m_ready = (act == lat);
        m_rdata = m_read ? bus_line(m_addr) : '0;
        if (m_write && m_ready) bus_mem[int'(m_addr)] = m_wdata;
      end
      #1;
      if (bus.c_ready) begin
        done = 1'b1;
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          total++;
          if (cyc !== got.cycle) begin
            bad++;
            $error("FAIL %s/ready_cycle observed=%0d expected=%0d", name, cyc, got.cycle);
          end
          if (got.rd) begin
            total++;
            if (bus.c_rdata !== got.data) begin
              bad++;
              $error("FAIL %s/c_rdata observed=%0h expected=%0h", name, bus.c_rdata, got.data);
            end
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      m_ready = 1'b0;
      m_rdata = '0;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $error("FAIL %s/completed observed=%0h expected=1", name, done);
    end
    bus.c_read  = 1'b0;
    bus.c_write = 1'b0;
    total++;
    if (act !== exp_act) begin
      bad++;
      $error("FAIL %s/mem_active_cycles observed=%0d expected=%0d", name, act, exp_act);
    end
    total++;
    if ((m_read | m_write) !== 1'b0) begin
      bad++;
      $error("FAIL %s/mem_idle_after observed=%0h expected=0", name, m_read | m_write);
    end
    check_counts(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.c_read  = 1'b1;
    bus.c_write = 1'b0;
    bus.c_addr  = 16'h0010;
    bus.c_wdata = '0;
    m_ready     = 1'b0;
    m_rdata     = '0;
    r_hit       = 0;
    r_miss      = 0;
    for (int i = 0; i < 4; i++) begin
      r_valid[i] = 1'b0;
      r_tag[i]   = '0;
      for (int k = 0; k < 4; k++) r_data[i][k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      r_mem[16 + k]   = 16'(16'hA + k);
      bus_mem[16 + k] = 16'(16'hA + k);
    end

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.c_ready !== 1'b0) begin
      bad++;
      $error("FAIL reset/c_ready observed=%0h expected=0", bus.c_ready);
    end
    total++;
    if (bus.c_rdata !== 16'h0) begin
      bad++;
      $error("FAIL reset/c_rdata observed=%0h expected=0", bus.c_rdata);
    end
    total++;
    if (m_read !== 1'b0) begin
      bad++;
      $error("FAIL reset/m_read observed=%0h expected=0", m_read);
    end
    total++;
    if (m_write !== 1'b0) begin
      bad++;
      $error("FAIL reset/m_write observed=%0h expected=0", m_write);
    end
    total++;
    if (m_addr !== 16'h0) begin
      bad++;
      $error("FAIL reset/m_addr observed=%0h expected=0", m_addr);
    end
    total++;
    if (m_wdata !== 16'h0) begin
      bad++;
      $error("FAIL reset/m_wdata observed=%0h expected=0", m_wdata);
    end
    check_counts("reset");
    reset      = 1'b0;
    bus.c_read = 1'b0;

    access(1'b1, 1'b0, 16'h0010, 16'h0, 2, "rd_miss_0010");
    access(1'b1, 1'b0, 16'h0013, 16'h0, 2, "rd_hit_0013");
    access(1'b1, 1'b0, 16'h0020, 16'h0, 1, "conflict_0020");
    access(1'b1, 1'b0, 16'h0010, 16'h0, 2, "conflict_0010");
    access(1'b0, 1'b1, 16'h0011, 16'h1234, 3, "wr_hit_0011");
    access(1'b1, 1'b0, 16'h0011, 16'h0, 2, "rd_after_wr_0011");
    access(1'b0, 1'b1, 16'h0040, 16'h5555, 2, "wr_miss_0040");
    access(1'b1, 1'b0, 16'h0040, 16'h0, 1, "rd_no_alloc_0040");
    access(1'b1, 1'b1, 16'h0043, 16'hBEEF, 2, "rd_and_wr_0043");
    access(1'b1, 1'b0, 16'h0043, 16'h0, 2, "rd_check_0043");
    access(1'b0, 1'b1, 16'h00F6, 16'h0777, 1, "wr_miss_00f6");
    access(1'b1, 1'b0, 16'h00F6, 16'h0, 3, "rd_fill_00f6");

    // Reset lands in the first FILL cycle while memory answers.
    bus.c_read = 1'b1;
    bus.c_addr = 16'h0050;
    @(posedge clk);
    #1;
    total++;
    if (m_read !== 1'b1) begin
      bad++;
      $error("FAIL rst_fill/m_read_before observed=%0h expected=1", m_read);
    end
    reset   = 1'b1;
    m_ready = 1'b1;
    m_rdata = 64'h1111_2222_3333_4444;
    #1;
    total++;
    if (bus.c_ready !== 1'b0) begin
      bad++;
      $error("FAIL rst_fill/c_ready_in_reset observed=%0h expected=0", bus.c_ready);
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    m_ready    = 1'b0;
    m_rdata    = '0;
    bus.c_read = 1'b0;
    total++;
    if (m_read !== 1'b0) begin
      bad++;
      $error("FAIL rst_fill/m_read_after observed=%0h expected=0", m_read);
    end
    total++;
    if (m_addr !== 16'h0) begin
      bad++;
      $error("FAIL rst_fill/m_addr_after observed=%0h expected=0", m_addr);
    end
    for (int i = 0; i < 4; i++) r_valid[i] = 1'b0;
    r_hit  = 0;
    r_miss = 0;
    check_counts("rst_fill");
    access(1'b1, 1'b0, 16'h0050, 16'h0, 2, "post_reset_0050");
    access(1'b1, 1'b0, 16'h0011, 16'h0, 1, "post_reset_0011");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
